// File: rtl/axi4_slave_pkg.sv
// Shared response codes and FSM state types for the AXI4 slave responder.
package axi4_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } write_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } read_state_t;

endpackage

// File: rtl/axi4_slave_ram.sv
// Byte-enabled RAM backing the responder window: one synchronous write port,
// one asynchronous read port. Contents are never reset.
module axi4_slave_ram
    import axi4_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int MEM_WORDS  = 256,
    parameter int IDX_W      = 8
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [IDX_W-1:0]        waddr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic [IDX_W-1:0]        raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Read-before-write: a same-cycle write lands at the edge, after the read is sampled.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi4_slave_responder.sv
// AXI4 INCR-only slave terminating burst-master traffic into a RAM window at BASE_ADDR.
// Independent write (AW/W/B) and read (AR/R) FSMs share one dual-port RAM.
module axi4_slave_responder
    import axi4_slave_pkg::*;
#(
    parameter int                    ID_WIDTH   = 6,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h10000000),
    parameter int                    MEM_WORDS  = 256
) (
    input  logic                    CLOCK,
    input  logic                    RESET,
    input  logic [ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]              S_AXI_AWLEN,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                    S_AXI_WLAST,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]              S_AXI_ARLEN,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [ID_WIDTH-1:0]     S_AXI_RID,
    output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RLAST,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(STRB_W);
    localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(MEM_WORDS * STRB_W);

    // Unsigned offset wraps below BASE_ADDR, so one compare covers both window edges.
    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr);
        return (addr - BASE_ADDR) < WIN_BYTES;
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> LSB);
    endfunction

    write_state_t          wstate_q;
    logic                  awready_q, wready_q, bvalid_q;
    logic [1:0]            bresp_q;
    logic [ID_WIDTH-1:0]   bid_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [7:0]            wlen_q, wcnt_q;
    logic                  dec_q, slv_q;

    read_state_t           rstate_q;
    logic                  arready_q, rvalid_q, rlast_q;
    logic [1:0]            rresp_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic [7:0]            rlen_q, rcnt_q;

    logic                  w_beat, w_in_win, w_last_beat, dec_d, slv_d;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_in_win;
    logic [DATA_WIDTH-1:0] ram_rdata, rd_word;
    logic [1:0]            rd_resp;

    assign w_beat      = (wstate_q == W_DATA) && S_AXI_WVALID && wready_q;
    assign w_in_win    = in_window(waddr_q);
    assign w_last_beat = (wcnt_q == wlen_q);
    assign dec_d       = dec_q | (w_beat & ~w_in_win);
    assign slv_d       = slv_q | (w_beat & (S_AXI_WLAST != w_last_beat));

    // While idle the RAM is looked up at ARADDR so beat 0 can be registered on the AR handshake.
    assign rd_addr   = (rstate_q == R_IDLE) ? S_AXI_ARADDR : raddr_q;
    assign rd_in_win = in_window(rd_addr);
    assign rd_word   = rd_in_win ? ram_rdata : '0;
    assign rd_resp   = rd_in_win ? RESP_OKAY : RESP_DECERR;

    axi4_slave_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk_i   (CLOCK),
        .we_i    (w_beat && w_in_win),
        .waddr_i (word_index(waddr_q)),
        .wdata_i (S_AXI_WDATA),
        .wstrb_i (S_AXI_WSTRB),
        .raddr_i (word_index(rd_addr)),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            dec_q     <= 1'b0;
            slv_q     <= 1'b0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (S_AXI_AWVALID && awready_q) begin
                        bid_q     <= S_AXI_AWID;
                        waddr_q   <= S_AXI_AWADDR;
                        wlen_q    <= S_AXI_AWLEN;
                        wcnt_q    <= '0;
                        dec_q     <= 1'b0;
                        slv_q     <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        wstate_q  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        dec_q   <= dec_d;
                        slv_q   <= slv_d;
                        waddr_q <= waddr_q + STEP;
                        wcnt_q  <= wcnt_q + 8'd1;
                        // Burst length follows AWLEN regardless of where WLAST lands.
                        if (w_last_beat) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= dec_d ? RESP_DECERR : (slv_d ? RESP_SLVERR : RESP_OKAY);
                            wstate_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= RESP_OKAY;
                        awready_q <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rid_q     <= '0;
            rdata_q   <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (S_AXI_ARVALID && arready_q) begin
                        rid_q     <= S_AXI_ARID;
                        rlen_q    <= S_AXI_ARLEN;
                        rcnt_q    <= '0;
                        raddr_q   <= S_AXI_ARADDR + STEP;
                        rdata_q   <= rd_word;
                        rresp_q   <= rd_resp;
                        rlast_q   <= (S_AXI_ARLEN == 8'd0);
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        rstate_q  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            rresp_q   <= RESP_OKAY;
                            rdata_q   <= '0;
                            arready_q <= 1'b1;
                            rstate_q  <= R_IDLE;
                        end else begin
                            rdata_q <= rd_word;
                            rresp_q <= rd_resp;
                            rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
                            rcnt_q  <= rcnt_q + 8'd1;
                            raddr_q <= raddr_q + STEP;
                        end
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_BID     = bid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RID     = rid_q;
    assign S_AXI_RDATA   = rdata_q;

endmodule

// File: doc/axi4_slave_responder.md
# axi4_slave_responder

AXI4 memory-mapped slave that terminates the traffic produced by the team's AXI4 burst master: it accepts INCR write bursts into an internal RAM window at BASE_ADDR and returns that data on INCR read bursts. It sits in the block design opposite the master, behind the protocol checker, and gives the master bench a deterministic, self-contained target. Only full-width beats are handled; AxSIZE/AxBURST are not ports, and every burst is treated as INCR of DATA_WIDTH/8 bytes per beat.

## Interface
- ID_WIDTH, 6, AXI ID width
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 256, data width; power of two, at least 32
- BASE_ADDR, 32'h10000000, first byte address of the window
- MEM_WORDS, 256, RAM depth in DATA_WIDTH words; power of two
- CLOCK  in  1  sole clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- S_AXI_AWID  in  ID_WIDTH  write burst ID
- S_AXI_AWADDR  in  ADDR_WIDTH  write start byte address
- S_AXI_AWLEN  in  8  beats minus one
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake
- S_AXI_WDATA  in  DATA_WIDTH  write data
- S_AXI_WSTRB  in  DATA_WIDTH/8  byte enables
- S_AXI_WLAST  in  1  master's last-beat flag
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake
- S_AXI_BID  out  ID_WIDTH  echoed AWID
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake
- S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN  in  ID_WIDTH / ADDR_WIDTH / 8  read request
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake
- S_AXI_RID  out  ID_WIDTH  echoed ARID
- S_AXI_RDATA  out  DATA_WIDTH  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RLAST  out  1  last read beat
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake

## Operation
- Beat address: start + k·(DATA_WIDTH/8). It is in the window if BASE_ADDR ≤ addr < BASE_ADDR + MEM_WORDS·DATA_WIDTH/8. The word index is (addr−BASE_ADDR)>>log2(DATA_WIDTH/8). The low address bits are ignored.
- Write FSM W_IDLE→W_DATA→W_RESP→W_IDLE:
  - W_IDLE: AWREADY=1. On the handshake, latch ID, address and LEN; clear the beat counter and the error flags.
  - W_DATA: WREADY=1. Each accepted beat writes the strobed bytes when in the window; when out of the window, the beat is dropped and the DECERR flag is set.
  - If WLAST≠(count==LEN), set the SLVERR flag. Burst length always follows AWLEN.
  - Leave W_DATA after beat LEN.
  - W_RESP: BVALID=1; BRESP is DECERR(11) if flagged, else SLVERR(10) if flagged, else OKAY(00). Hold until BREADY.
- Read FSM R_IDLE→R_DATA→R_IDLE:
  - R_IDLE: ARREADY=1. On the handshake, latch ID/LEN and load RDATA from the start word.
  - R_DATA: RVALID=1. RDATA/RRESP/RLAST are registered and stable while RREADY=0. Each accepted beat loads the next word.
  - Out-of-window beats return zero data with DECERR. RLAST=1 on beat LEN. Return to R_IDLE after the last handshake.
- Read and write FSMs are independent and run concurrently. When a write and a read-data load hit the same word in the same cycle, the read returns the pre-write data.
- RAM is not reset; its contents are undefined until written.

## Timing
- Reset values: all READY/VALID, BRESP, RRESP, RLAST, BID, RID and RDATA are 0. FSMs are in IDLE. AWREADY/ARREADY rise at the first rising edge after RESET falls.
- AW handshake at edge T: WREADY=1 from T+1. BVALID=1 on the cycle after the last W beat. AWREADY=1 on the cycle after the B handshake.
- AR handshake at T: RVALID=1 with beat 0 from T+1. Beats are back-to-back while RREADY=1. ARREADY=1 on the cycle after the last R handshake.
- RESET mid-burst: the burst is abandoned immediately, outputs go to their reset values, and already-written beats remain in RAM.

## Structure
- axi4_slave_pkg: RESP_OKAY/RESP_SLVERR/RESP_DECERR constants; write_state_t and read_state_t enums.
- Sub-module axi4_slave_ram: MEM_WORDS×DATA_WIDTH, one byte-enabled write port, one asynchronous read port. The responder registers RDATA.

## Test plan
- Write AWADDR=0x10000000, AWLEN=3, data 0x11..0x44, WSTRB all ones, BREADY=1 → BRESP=00, BID=AWID. Then read ARLEN=3 → four beats 0x11..0x44, RLAST only on beat 3.
- Write AWLEN=0 with WSTRB=0x0000000F over a word pre-filled with all ones → read back shows only bytes 0–3 changed.
- Write AWADDR=0x0FFFFFE0, AWLEN=1 → beat 0 dropped, BRESP=11. Read ARADDR=0x0FFFFFE0 → beat 0 RDATA=0 with RRESP=11, beat 1 RRESP=00.
- Write AWLEN=2 with WLAST asserted on beat 1 → three beats accepted, BRESP=10.
- Read AWLEN=7 with RREADY toggling 1/0 each cycle → RDATA/RLAST stable while stalled; eight beats, in order.
- Assert RESET during beat 2 of an AWLEN=7 write → all outputs 0 the same cycle, AWREADY=1 on the first edge after release, beats 0–1 readable.
